// File: rtl/universal_shift_reg_if.sv
// Signal bundle for universal_shift_reg: mode/serial/parallel controls from the
// requester (master) and register contents plus busy/done status from the shifter (slave).
interface universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] p_in;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] d_out;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sin_r, sin_l, p_in, start, amount,
        input  d_out, sout_r, sout_l, busy, done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, p_in, start, amount,
        output d_out, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: single-step shift/rotate/load plus a
// multi-step engine that repeats one latched operation N times behind busy/done.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    universal_shift_reg_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_ROR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ASR   = 3'b101;
    localparam logic [2:0] M_LOAD  = 3'b110;
    localparam logic [2:0] M_HOLD2 = 3'b111;

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [AMT_W-1:0] cnt_q, cnt_n;
    logic [2:0]       mode_q, mode_n;
    logic             done_q, done_n;

    function automatic logic is_shift(input logic [2:0] m);
        return (m != M_HOLD) && (m != M_LOAD) && (m != M_HOLD2);
    endfunction

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] r,
        input logic             sr,
        input logic             sl,
        input logic [WIDTH-1:0] p
    );
        case (m)
            M_SHR:   return {sr, r[WIDTH-1:1]};
            M_SHL:   return {r[WIDTH-2:0], sl};
            M_ROR:   return {r[0], r[WIDTH-1:1]};
            M_ROL:   return {r[WIDTH-2:0], r[WIDTH-1]};
            M_ASR:   return {r[WIDTH-1], r[WIDTH-1:1]};
            M_LOAD:  return p;
            default: return r;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            mode_q <= M_HOLD;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            cnt_q  <= cnt_n;
            mode_q <= mode_n;
            done_q <= done_n;
        end
    end

    // done is a single-cycle pulse, so it defaults low on every edge, enabled or not.
    always_comb begin
        state_n = state;
        data_n  = data_q;
        cnt_n   = cnt_q;
        mode_n  = mode_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    if (bus.start) begin
                        mode_n = bus.mode;
                        if (is_shift(bus.mode) && (bus.amount != CNT_ZERO)) begin
                            state_n = RUN;
                            cnt_n   = bus.amount;
                        end else begin
                            done_n = 1'b1;
                        end
                    end else begin
                        data_n = apply_op(bus.mode, data_q, bus.sin_r, bus.sin_l, bus.p_in);
                    end
                end
            end
            RUN: begin
                // Serial inputs stay live during a run; mode, p_in and start do not.
                if (bus.en) begin
                    data_n = apply_op(mode_q, data_q, bus.sin_r, bus.sin_l, bus.p_in);
                    cnt_n  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.d_out  = data_q;
    assign bus.sout_r = data_q[0];
    assign bus.sout_l = data_q[WIDTH-1];
    assign bus.busy   = (state == RUN);
    assign bus.done   = done_q;
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register, the successor to the team's fixed 4-bit left/right serial shifter. Adds configurable width, parallel load, rotate and arithmetic-right modes, and a multi-step shift engine that performs N shifts from one `start` request with a busy/done handshake. It is used wherever datapath logic needs serialisation, bit alignment or barrel-style shifting spread over several cycles.

## Interface
- `WIDTH`, 8: register width in bits, minimum 2.
- `AMT_W`, 4: width of `amount`. Shift counts range from 0 to 2^AMT_W-1.
- `clk` input 1: single clock. All state updates occur on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: global enable. When low, the register and the counter hold.
- `mode` input 3: operation select.
  - 000: hold.
  - 001: shift right (logical).
  - 010: shift left.
  - 011: rotate right.
  - 100: rotate left.
  - 101: arithmetic shift right.
  - 110: parallel load.
  - 111: hold.
- `sin_r` input 1: serial input entering the MSB on a logical shift right.
- `sin_l` input 1: serial input entering the LSB on a shift left.
- `p_in` input WIDTH: parallel load data.
- `start` input 1: request a multi-step operation.
- `amount` input AMT_W: number of steps for a multi-step operation.
- `d_out` output WIDTH: register contents.
- `sout_r` output 1: equals `d_out[0]`.
- `sout_l` output 1: equals `d_out[WIDTH-1]`.
- `busy` output 1: high while a multi-step operation is in progress.
- `done` output 1: one-cycle pulse marking the end of a multi-step operation.

## Operation
- **Reset** (asynchronous, takes effect immediately): `d_out`=0, `busy`=0, `done`=0, counter=0, latched mode=000, state=IDLE.
- **Single-step mode** (IDLE, `start`=0, `en`=1): `mode` is applied once per edge.
  - 001: {sin_r, r[W-1:1]}
  - 010: {r[W-2:0], sin_l}
  - 011: {r[0], r[W-1:1]}
  - 100: {r[W-2:0], r[W-1]}
  - 101: {r[W-1], r[W-1:1]}
  - 110: r = `p_in`
- **Start** (IDLE, `start`=1, `en`=1):
  - Latches `mode` and `amount`. No register update occurs on the accepting edge.
  - If the latched mode is 001–101 and `amount`>0: go to RUN, counter=`amount`.
  - Otherwise (amount=0, or mode 000/110/111): stay in IDLE, register unchanged, `done`=1 next cycle.
- **Start ignored:** `start` with `en`=0 is ignored in IDLE and is not remembered.
- **RUN:**
  - Each edge with `en`=1 applies the latched mode and decrements the counter.
  - `sin_r` and `sin_l` are sampled live on each edge.
  - Live `mode`, `p_in` and `start` are ignored.
  - The edge on which the counter goes from 1 to 0 performs the last shift and returns to IDLE with `done`=1.
- **Stall:** `en`=0 in RUN holds the register, counter and state. It does not abort the operation.
- **Large amounts:** `amount` > WIDTH is legal. Rotates wrap modulo WIDTH, and logical shifts keep filling with serial input.
- **done:** registered; high for exactly one cycle, then cleared on the next edge regardless of `en`.
- **busy:** registered; equals (state == RUN).
- **Back-to-back:** a new `start` is accepted in the cycle where `done`=1, because the state is IDLE.

## Timing
- Single-step and parallel load: 1-cycle latency, with `d_out` updated on the edge that samples `mode`.
- Multi-step with start accepted at edge k and `en` held high:
  - `busy`=1 after edge k.
  - Shifts occur at edges k+1 through k+N.
  - After edge k+N: `busy`=0 and `done`=1, for one cycle.
- Each stalled cycle (`en`=0) extends `busy` by one cycle.
- Zero or non-shift start at edge k: `busy` stays 0; `done`=1 after edge k.
- `sout_r` and `sout_l` are combinational from `d_out` and add no latency.
- Reset asserted mid-RUN aborts immediately. There is no `done` pulse, and after release the block is in IDLE.

## Test plan
- **Load and single steps** (WIDTH=8):
  - Load 8'hA5 via mode 110 -> `d_out`=A5.
  - From A5, one step each (reload A5 before each step):
    - 001 with sin_r=0 -> 52.
    - 010 with sin_l=0 -> 4A.
    - 101 -> D2.
    - 100 -> 4B.
- **Multi-step rotate:**
  - Stimulus: `d_out`=8'h81, start with mode 011 and amount=3.
  - Required: `busy` high 3 cycles, `d_out`=30, `done` pulses 1 cycle after the last shift.
- **Stall:** same operation as above with `en`=0 for 2 cycles mid-RUN -> `busy` high 5 cycles, final `d_out`=30, no extra shifts.
- **Zero amount and ignored start:**
  - amount=0 -> `done` next cycle, `busy` never high, `d_out` unchanged.
  - `start` pulsed during RUN -> ignored, and only one `done` pulse occurs.
- **Serial fill:**
  - Stimulus: from 00, start with mode 001, amount=10, sin_r pattern 1,0,1,1,0,0,1,0,1,1.
  - Required: `d_out`=8'hD3 (the last 8 bits sampled, in MSB-first entry order), single `done` pulse.
- **Asynchronous reset:**
  - Assert `rst` between clock edges mid-RUN -> `d_out`=0, `busy`=0, `done`=0 before the next edge.
  - After release, a single-step load of 8'h3C works.
